// File: rtl/pmem_burst_ctrl_pkg.sv
// pmem_ctrl_pkg: shared types and geometry helpers for the pmem burst controller.
//   pmem_state_t : controller FSM states
//   pmem_op_t    : latched request kind
//   OFF_W / BEAT_IDX_W : line-offset and beat-index widths for the default
//                        geometry (4 x 64-bit beats per 256-bit line)
package pmem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        DONE
    } pmem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

    localparam int unsigned OFF_W      = 5;
    localparam int unsigned BEAT_IDX_W = 2;

    // Byte-offset bits within one line of `beats` x `beat_w`-bit beats.
    function automatic int unsigned line_off_w(input int unsigned beats, input int unsigned beat_w);
        return $clog2(beats * beat_w / 8);
    endfunction

    // Beat counter width; BEATS must be at least 2.
    function automatic int unsigned beat_idx_w(input int unsigned beats);
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/pmem_burst_ctrl_if.sv
// pmem_burst_ctrl_if: the core-facing pmem_* line burst port.
//   pmem_read/pmem_write : request lines, held until the final response beat
//   pmem_address         : line byte address, stable for the whole request
//   pmem_wdata           : write beat, sampled on each response cycle of a write
//   pmem_resp            : one cycle per beat
//   pmem_rdata           : read beat while pmem_resp is high, 0 otherwise
// master = requester (cacheline adaptor), slave = memory controller.
interface pmem_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [BEAT_W-1:0] pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_burst_ctrl.sv
// pmem_burst_ctrl: physical-memory controller behind the pmem_* burst port.
// Serves one line read or write at a time as BEATS beats after a modelled
// DRAM latency, using a single-port synchronous beat-wide SRAM (1-cycle read).
//   clk, reset_n   : clock, asynchronous active-low reset
//   pmem           : pmem_* burst port (slave side)
//   sram_en/we     : SRAM access enable / write enable
//   sram_addr      : beat address {line_addr, beat_idx}
//   sram_wdata     : SRAM write data (pmem_wdata passed straight through)
//   sram_rdata     : SRAM read data, valid one cycle after a read issue
//   busy           : controller not in IDLE
//   proto_err      : sticky protocol-violation flag, cleared only by reset
module pmem_burst_ctrl
    import pmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BEAT_W  = 64,
    parameter int unsigned BEATS   = 4,
    parameter int unsigned LATENCY = 8   // 1..255
) (
    input  logic              clk,
    input  logic              reset_n,
    pmem_burst_ctrl_if.slave  pmem,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-4:0] sram_addr,
    output logic [BEAT_W-1:0] sram_wdata,
    input  logic [BEAT_W-1:0] sram_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned LINE_OFF_W = line_off_w(BEATS, BEAT_W);
    localparam int unsigned IDX_W      = beat_idx_w(BEATS);
    localparam int unsigned LINE_W     = ADDR_W - LINE_OFF_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
    localparam logic [7:0]       LAT_INIT  = 8'(LATENCY - 1);

    pmem_state_t       state, state_nxt;
    pmem_op_t          op_q;
    logic [LINE_W-1:0] line_addr;
    logic [7:0]        lat_cnt;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  addr_idx;
    logic [LINE_W-1:0] req_line;
    logic              req_any;
    logic              viol;
    logic              unused_addr_bits;

    assign req_line         = pmem.pmem_address[ADDR_W-1:LINE_OFF_W];
    assign req_any          = pmem.pmem_read | pmem.pmem_write;
    assign unused_addr_bits = ^pmem.pmem_address[LINE_OFF_W-1:0];

    assign sram_addr  = {line_addr, addr_idx};
    assign sram_wdata = pmem.pmem_wdata;
    assign pmem.pmem_rdata = (state == RBURST) ? sram_rdata : '0;

    // While a request is in flight the requester must keep exactly the latched
    // op asserted at the latched line; DONE deliberately tolerates anything.
    always_comb begin
        viol = 1'b0;
        case (state)
            IDLE:   viol = pmem.pmem_read & pmem.pmem_write;
            WAIT, RBURST, WBURST: begin
                if (op_q == OP_READ) viol = ~pmem.pmem_read | pmem.pmem_write;
                else                 viol = ~pmem.pmem_write | pmem.pmem_read;
                if (req_line != line_addr) viol = 1'b1;
            end
            default: viol = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        pmem.pmem_resp = 1'b0;
        sram_en        = 1'b0;
        sram_we        = 1'b0;
        addr_idx       = beat_idx;
        busy           = (state != IDLE);
        case (state)
            IDLE: if (req_any) state_nxt = WAIT;
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (op_q == OP_READ) begin
                        sram_en   = 1'b1;        // beat 0 read, data lands in first RBURST cycle
                        state_nxt = RBURST;
                    end else begin
                        state_nxt = WBURST;
                    end
                end
            end
            RBURST: begin
                pmem.pmem_resp = 1'b1;
                if (beat_idx != LAST_BEAT) begin
                    sram_en  = 1'b1;             // prefetch next beat
                    addr_idx = beat_idx + IDX_W'(1);
                end else begin
                    state_nxt = DONE;
                end
            end
            WBURST: begin
                pmem.pmem_resp = 1'b1;
                sram_en        = 1'b1;
                sram_we        = 1'b1;
                if (beat_idx == LAST_BEAT) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= OP_READ;
            line_addr <= '0;
            lat_cnt   <= '0;
            beat_idx  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (viol) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        line_addr <= req_line;
                        op_q      <= pmem.pmem_read ? OP_READ : OP_WRITE;
                        lat_cnt   <= LAT_INIT;
                        beat_idx  <= '0;
                    end
                end
                WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 8'd1;
                RBURST, WBURST: beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_burst_ctrl.sv
// tb_pmem_burst_ctrl: two controller instances (LATENCY 8 and LATENCY 1) sharing
// one behavioural SRAM; only one is ever active. A line-level reference memory
// predicts every read beat, and the response/SRAM timetable of each request is
// derived from acceptance cycle 0: SRAM issue at cycle LATENCY (reads),
// responses at LATENCY+1 .. LATENCY+4, DONE at LATENCY+5.
module tb_pmem_burst_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic mem_clr;

    pmem_burst_ctrl_if #(.ADDR_W(32), .BEAT_W(64)) bus0 ();
    pmem_burst_ctrl_if #(.ADDR_W(32), .BEAT_W(64)) bus1 ();

    logic        en0, we0, busy0, perr0, en1, we1, busy1, perr1;
    logic [28:0] sa0, sa1;
    logic [63:0] swd0, swd1, srd0, srd1;

    pmem_burst_ctrl #(.ADDR_W(32), .BEAT_W(64), .BEATS(4), .LATENCY(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .pmem(bus0),
        .sram_en(en0), .sram_we(we0), .sram_addr(sa0), .sram_wdata(swd0),
        .sram_rdata(srd0), .busy(busy0), .proto_err(perr0)
    );

    pmem_burst_ctrl #(.ADDR_W(32), .BEAT_W(64), .BEATS(4), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pmem(bus1),
        .sram_en(en1), .sram_we(we1), .sram_addr(sa1), .sram_wdata(swd1),
        .sram_rdata(srd1), .busy(busy1), .proto_err(perr1)
    );

    function automatic logic [63:0] init_val(input int unsigned a);
        return {32'hC0DE_0000 | a, a * 32'h9E37_79B9};
    endfunction

    // Behavioural SRAM: never-written words read as init_val(address).
    logic [63:0] mem   [0:4095];
    logic        wflag [0:4095];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) wflag[i] <= 1'b0;
        end else begin
            if (en0) begin
                if (we0) begin mem[sa0[11:0]] <= swd0; wflag[sa0[11:0]] <= 1'b1; end
                else srd0 <= wflag[sa0[11:0]] ? mem[sa0[11:0]] : init_val(32'(sa0[11:0]));
            end
            if (en1) begin
                if (we1) begin mem[sa1[11:0]] <= swd1; wflag[sa1[11:0]] <= 1'b1; end
                else srd1 <= wflag[sa1[11:0]] ? mem[sa1[11:0]] : init_val(32'(sa1[11:0]));
            end
        end
    end

    logic [63:0] ref_mem [0:4095];
    logic [1:0]  exp_perr;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [63:0] wd);
        if (sel == 0) begin
            bus0.pmem_read = rd; bus0.pmem_write = wr; bus0.pmem_address = a; bus0.pmem_wdata = wd;
        end else begin
            bus1.pmem_read = rd; bus1.pmem_write = wr; bus1.pmem_address = a; bus1.pmem_wdata = wd;
        end
    endtask

    task automatic obs(input int sel, output logic resp, output logic [63:0] rdata,
                       output logic en, output logic we, output logic [28:0] sa,
                       output logic [63:0] wd, output logic busy, output logic perr);
        if (sel == 0) begin
            resp = bus0.pmem_resp; rdata = bus0.pmem_rdata; en = en0; we = we0;
            sa = sa0; wd = swd0; busy = busy0; perr = perr0;
        end else begin
            resp = bus1.pmem_resp; rdata = bus1.pmem_rdata; en = en1; we = we1;
            sa = sa1; wd = swd1; busy = busy1; perr = perr1;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One request starting in the current IDLE cycle (cycle 0).
    //   drop_k >= 0 : request lines low from beat drop_k on
    //   chg         : line address altered from cycle 2 on
    //   hold_done   : keep the request high through DONE
    //   rst_k >= 0  : assert reset during beat rst_k and abandon the request
    task automatic txn(input int sel, input bit is_rd, input bit both, input logic [31:0] addr,
                       input int drop_k, input bit chg, input bit hold_done, input int rst_k);
        int          lat;
        logic [28:0] base, ba;
        logic [63:0] wd [4];
        logic        resp, en, we, busy, perr, rd_d, wr_d;
        logic [63:0] rdata, swd, wdv;
        logic [28:0] sa;
        logic [31:0] a_d;
        bit          rd_op;
        lat   = (sel == 0) ? 8 : 1;
        base  = {addr[31:5], 2'b00};
        rd_op = is_rd | both;
        for (int k = 0; k < 4; k++) wd[k] = rnd64();
        @(negedge clk);
        set_req(1 - sel, 1'b0, 1'b0, '0, '0);
        set_req(sel, rd_op, ~is_rd | both, addr, rnd64());
        #1;
        obs(sel, resp, rdata, en, we, sa, swd, busy, perr);
        check("accept_busy", {63'd0, busy}, 64'd0);
        check("accept_resp", {63'd0, resp}, 64'd0);
        if (both) exp_perr[sel] = 1'b1;
        if (chg || (drop_k >= 0 && drop_k <= 3)) exp_perr[sel] = 1'b1;
        for (int c = 1; c <= lat + 5; c++) begin
            int k;
            bit inb, exp_en;
            k   = c - lat - 1;
            inb = (k >= 0) && (k < 4);
            @(negedge clk);
            rd_d = rd_op; wr_d = ~is_rd | both; a_d = addr;
            if (drop_k >= 0 && k >= drop_k) begin rd_d = 1'b0; wr_d = 1'b0; end
            if (chg && c >= 2) a_d = addr ^ 32'h20;
            if (c == lat + 5 && !hold_done) begin rd_d = 1'b0; wr_d = 1'b0; end
            wdv = (inb && !rd_op) ? wd[k] : rnd64();
            set_req(sel, rd_d, wr_d, a_d, wdv);
            #1;
            obs(sel, resp, rdata, en, we, sa, swd, busy, perr);
            check("busy", {63'd0, busy}, 64'd1);
            check("resp", {63'd0, resp}, {63'd0, inb});
            ba = base + 29'(k);
            check("rdata", rdata, (rd_op && inb) ? ref_mem[ba[11:0]] : 64'd0);
            if (rd_op) begin
                exp_en = (c == lat) || (inb && k < 3);
                check("rd_sram_en", {63'd0, en}, {63'd0, exp_en});
                if (exp_en) begin
                    check("rd_sram_we", {63'd0, we}, 64'd0);
                    check("rd_sram_addr", {35'd0, sa}, {35'd0, base + ((c == lat) ? 29'd0 : 29'(k + 1))});
                end
            end else begin
                check("wr_sram_en", {63'd0, en}, {63'd0, inb});
                if (inb) begin
                    check("wr_sram_we", {63'd0, we}, 64'd1);
                    check("wr_sram_addr", {35'd0, sa}, {35'd0, ba});
                    check("wr_sram_wdata", swd, wd[k]);
                end
            end
            if (c == lat + 5) check("proto_err", {63'd0, perr}, {63'd0, exp_perr[sel]});
            if (rst_k >= 0 && k == rst_k) begin
                #1 reset_n = 1'b0;
                #1;
                obs(sel, resp, rdata, en, we, sa, swd, busy, perr);
                check("rst_resp", {63'd0, resp}, 64'd0);
                check("rst_sram_en", {63'd0, en}, 64'd0);
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_rdata", rdata, 64'd0);
                check("rst_perr", {63'd0, perr}, 64'd0);
                set_req(sel, 1'b0, 1'b0, '0, '0);
                exp_perr = '0;
                return;
            end
        end
        if (!rd_op) begin
            for (int k = 0; k < 4; k++) begin
                ba = base + 29'(k);
                ref_mem[ba[11:0]] = wd[k];
            end
        end
    endtask

    task automatic idle_chk(input int sel);
        logic        resp, en, we, busy, perr;
        logic [63:0] rdata, swd;
        logic [28:0] sa;
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        obs(sel, resp, rdata, en, we, sa, swd, busy, perr);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_resp", {63'd0, resp}, 64'd0);
        check("idle_perr", {63'd0, perr}, {63'd0, exp_perr[sel]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        exp_perr = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic        resp, en, we, busy, perr;
        logic [63:0] rdata, swd;
        logic [28:0] sa;
        int          sel, kind, drop_k, rst_k;
        bit          is_rd, both, chg, hold;
        logic [31:0] addr;

        for (int unsigned i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        exp_perr = '0;
        reset_n  = 1'b0;
        mem_clr  = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            obs(s, resp, rdata, en, we, sa, swd, busy, perr);
            check("reset_resp", {63'd0, resp}, 64'd0);
            check("reset_rdata", rdata, 64'd0);
            check("reset_sram_en", {63'd0, en}, 64'd0);
            check("reset_sram_we", {63'd0, we}, 64'd0);
            check("reset_busy", {63'd0, busy}, 64'd0);
            check("reset_perr", {63'd0, perr}, 64'd0);
        end
        mem_clr = 1'b0;
        reset_n = 1'b1;

        // Directed: plain read, write + read-back, back-to-back.
        txn(0, 1, 0, 32'h0000_1040, -1, 0, 0, -1); idle_chk(0);
        txn(0, 0, 0, 32'h0000_2000, -1, 0, 0, -1); idle_chk(0);
        txn(0, 1, 0, 32'h0000_2000, -1, 0, 0, -1); idle_chk(0);
        txn(0, 1, 0, 32'h0000_0100, -1, 0, 1, -1);
        txn(0, 0, 0, 32'h0000_0120, -1, 0, 1, -1); idle_chk(0);
        txn(0, 1, 0, 32'h0000_0120, -1, 0, 0, -1); idle_chk(0);

        // Reset during beat 2, then a normal read.
        txn(0, 1, 0, 32'h0000_0340, -1, 0, 0, 2);
        @(negedge clk); reset_n = 1'b1;
        idle_chk(0);
        txn(0, 1, 0, 32'h0000_0340, -1, 0, 0, -1); idle_chk(0);

        // Protocol errors: simultaneous request, then early drop; sticky until reset.
        txn(0, 1, 1, 32'h0000_0560, -1, 0, 0, -1); idle_chk(0);
        txn(0, 1, 0, 32'h0000_0580, 2, 0, 0, -1); idle_chk(0);
        txn(0, 1, 0, 32'h0000_05A0, -1, 0, 0, -1); idle_chk(0);
        do_reset(); idle_chk(0);

        // LATENCY=1 with an unaligned address.
        txn(1, 1, 0, 32'h0000_105C, -1, 0, 0, -1); idle_chk(1);

        // Randomized mix.
        for (int n = 0; n < 48; n++) begin
            sel    = $urandom_range(0, 1);
            is_rd  = ($urandom_range(0, 1) == 1);
            kind   = $urandom_range(0, 11);
            addr   = $urandom_range(0, 32'h7FFF);
            both   = (kind == 0);
            drop_k = (kind == 1) ? $urandom_range(1, 3) : -1;
            chg    = (kind == 2);
            rst_k  = (kind == 3) ? $urandom_range(0, 3) : -1;
            hold   = ($urandom_range(0, 1) == 1);
            if (both) is_rd = 1'b1;
            txn(sel, is_rd, both, addr, drop_k, chg, hold, rst_k);
            if (rst_k >= 0) begin
                @(negedge clk); reset_n = 1'b1;
                idle_chk(sel);
            end else if ($urandom_range(0, 2) == 0) begin
                idle_chk(sel);
            end
            if (n % 12 == 11) begin do_reset(); idle_chk(sel); end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
